// File: rtl/stall_sequencer.sv
// Pipeline stall sequencer: turns hazard-detector stall requests into PC / IF/ID / ID/EX
// freeze and bubble controls, holds the second cycle of a two-cycle stall itself.
module stall_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       hazard_stall,
  input  logic             flush_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             stall_active,
  output logic [1:0]       hold_remaining,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [1:0]       r_hold_remaining;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_freeze;
  logic             w_cnt_sat;

  assign w_freeze  = (r_state == S_HOLD) || (hazard_stall != 2'd0);
  assign w_cnt_sat = &r_stall_cycles;

  // Control outputs are combinational so a stall bites in the cycle it is requested.
  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    stall_active = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (flush_req) begin
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (w_freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_active = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_hold_remaining <= 2'd0;
      r_stall_cycles   <= '0;
    end else begin
      if (flush_req) begin
        r_state          <= S_IDLE;
        r_hold_remaining <= 2'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            // Encoding 3 is never produced upstream; treat it as a two-cycle request.
            if (hazard_stall[1]) begin
              r_state          <= S_HOLD;
              r_hold_remaining <= 2'd1;
            end
          end
          S_HOLD: begin
            if (r_hold_remaining <= 2'd1) begin
              r_state          <= S_IDLE;
              r_hold_remaining <= 2'd0;
            end else begin
              r_hold_remaining <= r_hold_remaining - 2'd1;
            end
          end
          default: begin
            r_state          <= S_IDLE;
            r_hold_remaining <= 2'd0;
          end
        endcase
      end
      if (stall_active && !w_cnt_sat) begin
        r_stall_cycles <= r_stall_cycles + CNT_ONE;
      end
    end
  end

  assign hold_remaining = r_hold_remaining;
  assign stall_cycles   = r_stall_cycles;

endmodule

// File: tb/tb_stall_sequencer.sv
// Bench for stall_sequencer: hand-computed vector table, counter saturation on a
// narrow instance, then random traffic compared against a cycle-count reference model.
module tb_stall_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  hazard_stall;
  logic        flush_req;

  logic        pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active;
  logic [1:0]  hold_remaining;
  logic [31:0] stall_cycles;

  logic        pc_write4, if_id_write4, id_ex_bubble4, if_id_flush4, stall_active4;
  logic [1:0]  hold_remaining4;
  logic [3:0]  stall_cycles4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  stall_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .flush_req(flush_req),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .stall_active(stall_active),
    .hold_remaining(hold_remaining), .stall_cycles(stall_cycles)
  );

  stall_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .flush_req(flush_req),
    .pc_write(pc_write4), .if_id_write(if_id_write4), .id_ex_bubble(id_ex_bubble4),
    .if_id_flush(if_id_flush4), .stall_active(stall_active4),
    .hold_remaining(hold_remaining4), .stall_cycles(stall_cycles4)
  );

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active}
  localparam logic [4:0] C_RUN = 5'b11000;
  localparam logic [4:0] C_FRZ = 5'b00101;
  localparam logic [4:0] C_FLS = 5'b11110;
  localparam logic [4:0] C_RST = 5'b00110;

  typedef struct {
    logic       r;
    logic [1:0] hs;
    logic       fl;
    logic [4:0] ctrl;
    logic [1:0] hold;
    int         cnt;
  } vec_t;

  // Reference model: extra freeze cycles still owed plus plain saturating counts.
  int      m_owed;
  longint  m_cnt32;
  int      m_cnt4;

  function automatic logic [4:0] model_ctrl(input logic r, input logic [1:0] hs,
                                            input logic fl, input int owed);
    if (r)                      return C_RST;
    if (fl)                     return C_FLS;
    if (owed > 0 || hs != 2'd0) return C_FRZ;
    return C_RUN;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [4:0] ctrl_of_dut();
    return {pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active};
  endfunction

  // Drive inputs shortly after a rising edge, leave time to settle before sampling.
  task automatic drive(input logic r, input logic [1:0] hs, input logic fl);
    rst = r; hazard_stall = hs; flush_req = fl;
    #2;
  endtask

  task automatic tick();
    logic frz;
    frz = (model_ctrl(rst, hazard_stall, flush_req, m_owed) == C_FRZ);
    @(posedge clk);
    if (rst) begin
      m_owed = 0; m_cnt32 = 0; m_cnt4 = 0;
    end else begin
      if (flush_req)         m_owed = 0;
      else if (m_owed > 0)   m_owed = m_owed - 1;
      else if (hazard_stall >= 2'd2) m_owed = 1;
      if (frz) begin
        if (m_cnt32 < 64'hFFFF_FFFF) m_cnt32 = m_cnt32 + 1;
        if (m_cnt4 < 15)             m_cnt4  = m_cnt4 + 1;
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ctrl"}, 64'(ctrl_of_dut()),
          64'(model_ctrl(rst, hazard_stall, flush_req, m_owed)));
    check({tag, "_hold"}, 64'(hold_remaining), 64'(m_owed));
    check({tag, "_cnt"},  64'(stall_cycles),   64'(m_cnt32));
    check({tag, "_cnt4"}, 64'(stall_cycles4),  64'(m_cnt4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[$];
    logic [1:0] hs_r;
    logic       fl_r, r_r;

    // Expected values are those seen during the cycle, before that cycle's edge.
    tab.push_back('{1'b1, 2'd0, 1'b0, C_RST, 2'd0, 0});
    tab.push_back('{1'b0, 2'd0, 1'b0, C_RUN, 2'd0, 0});
    tab.push_back('{1'b0, 2'd1, 1'b0, C_FRZ, 2'd0, 0});  // one-cycle stall
    tab.push_back('{1'b0, 2'd0, 1'b0, C_RUN, 2'd0, 1});
    tab.push_back('{1'b0, 2'd2, 1'b0, C_FRZ, 2'd0, 1});  // two-cycle stall
    tab.push_back('{1'b0, 2'd0, 1'b0, C_FRZ, 2'd1, 2});
    tab.push_back('{1'b0, 2'd0, 1'b0, C_RUN, 2'd0, 3});
    tab.push_back('{1'b0, 2'd3, 1'b0, C_FRZ, 2'd0, 3});  // illegal code acts as 2
    tab.push_back('{1'b0, 2'd1, 1'b0, C_FRZ, 2'd1, 4});  // input ignored in HOLD
    tab.push_back('{1'b0, 2'd0, 1'b0, C_RUN, 2'd0, 5});
    tab.push_back('{1'b0, 2'd2, 1'b0, C_FRZ, 2'd0, 5});  // flush discards HOLD
    tab.push_back('{1'b0, 2'd0, 1'b1, C_FLS, 2'd1, 6});
    tab.push_back('{1'b0, 2'd0, 1'b0, C_RUN, 2'd0, 6});
    tab.push_back('{1'b0, 2'd1, 1'b1, C_FLS, 2'd0, 6});  // flush beats stall
    tab.push_back('{1'b0, 2'd0, 1'b0, C_RUN, 2'd0, 6});
    tab.push_back('{1'b0, 2'd2, 1'b1, C_FLS, 2'd0, 6});
    tab.push_back('{1'b0, 2'd0, 1'b0, C_RUN, 2'd0, 6});
    tab.push_back('{1'b0, 2'd2, 1'b0, C_FRZ, 2'd0, 6});  // reset during HOLD
    tab.push_back('{1'b1, 2'd0, 1'b0, C_RST, 2'd1, 7});
    tab.push_back('{1'b0, 2'd0, 1'b0, C_RUN, 2'd0, 0});
    tab.push_back('{1'b0, 2'd1, 1'b0, C_FRZ, 2'd0, 0});
    tab.push_back('{1'b0, 2'd0, 1'b0, C_RUN, 2'd0, 1});

    m_owed = 0; m_cnt32 = 0; m_cnt4 = 0;
    rst = 1'b1; hazard_stall = 2'd0; flush_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    foreach (tab[i]) begin
      drive(tab[i].r, tab[i].hs, tab[i].fl);
      check($sformatf("vec%0d_ctrl", i), 64'(ctrl_of_dut()), 64'(tab[i].ctrl));
      check($sformatf("vec%0d_hold", i), 64'(hold_remaining), 64'(tab[i].hold));
      check($sformatf("vec%0d_cnt", i),  64'(stall_cycles),   64'(tab[i].cnt));
      tick();
    end

    // Counter saturation on the 4-bit instance: 20 back-to-back one-cycle stalls.
    drive(1'b1, 2'd0, 1'b0);
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 2'd1, 1'b0);
      check($sformatf("sat%0d_frz", k), 64'(stall_active4), 64'd1);
      tick();
    end
    drive(1'b0, 2'd0, 1'b0);
    check("sat_cnt4", 64'(stall_cycles4), 64'd15);
    check("sat_cnt32", 64'(stall_cycles), 64'd20);
    check("sat_run", 64'(pc_write4), 64'd1);
    tick();

    // Random traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      r_r  = ($urandom_range(0, 39) == 0);
      fl_r = ($urandom_range(0, 5) == 0);
      hs_r = 2'($urandom_range(0, 3));
      drive(r_r, hs_r, fl_r);
      check_model($sformatf("rnd%0d", k));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
